bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, range 0-15: memory wait states per access.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports cpu_req in 1, cpu_wr in 1, cpu_addr in 16, cpu_wdata in 16: CPU request, write flag, address, write data.
REQ-005 SHALL have ports cpu_rdata out 16, cpu_ack out 1: CPU read data, one-cycle completion strobe.
REQ-006 SHALL have ports ldr_req in 1, ldr_wr in 1, ldr_addr in 16, ldr_wdata in 16: program-loader request, write flag, address, write data.
REQ-007 SHALL have ports ldr_rdata out 16, ldr_ack out 1: loader read data, one-cycle completion strobe.
REQ-008 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 16, mem_wdata out 16, mem_rdata in 16: shared single-port memory.
REQ-009 SHALL have ports busy out 1 (state not IDLE) and owner out 1 (0=CPU, 1=loader; current or last grant).

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, ACK; all outputs registered.
REQ-011 IDLE, no request: SHALL stay IDLE, mem_en=0.
REQ-012 IDLE, exactly one request: SHALL grant it at that edge: latch addr/wdata/wr into mem_addr/mem_wdata/mem_we, mem_en=1, owner set, counter=WAIT_CYCLES, go ACCESS.
REQ-013 IDLE, both requests: SHALL grant the requester not granted last (round-robin on owner); first grant after reset SHALL go to CPU.
REQ-014 ACCESS, counter!=0: SHALL decrement counter, hold all mem_* outputs.
REQ-015 ACCESS, counter==0: SHALL capture mem_rdata into the owner's rdata, pulse owner's ack for one cycle, clear mem_en and mem_we, go ACK.
REQ-016 ACK: SHALL clear ack, go IDLE; requests are re-sampled in IDLE.
REQ-017 Latency: request sampled at edge k -> ack high after edge k+WAIT_CYCLES+1; next grant at earliest edge k+WAIT_CYCLES+3.
REQ-018 Non-owner rdata SHALL hold its last value; non-owner ack SHALL stay 0.
REQ-019 rdata SHALL update on writes too (value captured from mem_rdata).
REQ-020 Requester SHALL hold req and request fields until its ack; request fields are sampled only at grant, so changes after grant are ignored.
REQ-021 Request dropped mid-ACCESS: transaction SHALL complete and ack SHALL still pulse.
REQ-022 req still high in the cycle after ack SHALL be treated as a new transaction.
REQ-023 mem_en and mem_we SHALL never be 1 outside ACCESS; mem_we=1 only when the granted request had wr=1.

Reset
REQ-024 reset=0 SHALL asynchronously force state IDLE, counter 0, mem_en/mem_we/mem_addr/mem_wdata 0, cpu_rdata/ldr_rdata 0, cpu_ack/ldr_ack 0, busy 0, owner 1 (so CPU wins first tie).
REQ-025 Reset during ACCESS SHALL abort the transaction with no ack; after release, arbitration restarts from IDLE.
REQ-026 Release of reset SHALL take effect at the next rising clk edge; no output changes until then.

Verification
REQ-027 WAIT_CYCLES=1: CPU read 0x0010, mem_rdata=0xBEEF -> mem_en high 2 cycles, mem_addr=0x0010, mem_we=0; cpu_ack 1 cycle, cpu_rdata=0xBEEF; ldr_ack stays 0.
REQ-028 Loader write 0x0200<-0x1234 -> mem_we=1, mem_wdata=0x1234 during ACCESS only; ldr_ack pulses once; owner=1.
REQ-029 Both requests held 6 transactions from reset -> grant order CPU,LDR,CPU,LDR,CPU,LDR; exactly one ack per transaction; acks never coincide.
REQ-030 WAIT_CYCLES=0 and WAIT_CYCLES=15: request at edge k -> ack after edge k+1 and k+16 respectively.
REQ-031 Reset asserted mid-ACCESS -> all outputs 0 and owner=1 immediately (asynchronously), no ack; next CPU request served normally.
REQ-032 CPU changes cpu_addr and drops cpu_req one cycle after grant -> mem_addr keeps granted value, cpu_ack still pulses.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter for one shared single-port memory: the CPU and the program loader
// take turns, with a fixed number of wait states per access.
module bus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        ldr_req,
  input  logic        ldr_wr,
  input  logic [15:0] ldr_addr,
  input  logic [15:0] ldr_wdata,
  output logic [15:0] ldr_rdata,
  output logic        ldr_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        owner,
  output logic [1:0]  state_dbg
);

  // Handshake: a requester raises req with its fields stable and holds them until its
  // ack. Fields are sampled only at the grant edge; ack is a one-cycle strobe.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0] state;
  logic [3:0] count;
  logic       pick_ldr;

  assign state_dbg = state;

  // On a tie, the loader wins only when the CPU held the previous grant.
  always_comb begin
    pick_ldr = ldr_req && (!cpu_req || !owner);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      count     <= 4'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      cpu_rdata <= 16'h0000;
      ldr_rdata <= 16'h0000;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req || ldr_req) begin
            owner     <= pick_ldr;
            mem_en    <= 1'b1;
            mem_we    <= pick_ldr ? ldr_wr    : cpu_wr;
            mem_addr  <= pick_ldr ? ldr_addr  : cpu_addr;
            mem_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
            count     <= WAIT_INIT;
            busy      <= 1'b1;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            if (owner) begin
              ldr_rdata <= mem_rdata;
              ldr_ack   <= 1'b1;
            end else begin
              cpu_rdata <= mem_rdata;
              cpu_ack   <= 1'b1;
            end
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= S_ACK;
          end
        end
        S_ACK: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
